alu_logic_arbiter: RTL
======================

Name: alu_logic_arbiter

Overview:
- Shares one 16-bit bitwise logic unit (AND/OR/XOR/NOT) between two requesters, e.g. the instruction-execute path and the address/mask-generation path of the 16-bit processor.
- Round-robin arbitration, operand capture, a one-cycle registered execute and a held result with ack handshake.
- Sits between the requesters and the bitwise datapath. It is the only driver of the shared logic unit's operands.

Parameters:
- WIDTH, 16, operand/result width.
- CNTW, 16, width of completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 request.
- op0  in  2  requester 0 opcode.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  WIDTH  requester 0 operand B.
- gnt0  out  1  requester 0 grant; operands captured this cycle.
- req1  in  1  requester 1 request.
- op1  in  2  requester 1 opcode.
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- gnt1  out  1  requester 1 grant.
- res_valid  out  1  result available.
- res_data  out  WIDTH  result.
- res_id  out  1  requester that owns the result.
- res_ack  in  1  consumer accepts result.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNTW  completed (acked) operations, wraps.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - State goes to IDLE. gnt0, gnt1, res_valid, res_id and busy are 0.
  - res_data and op_count are 0.
  - The round-robin pointer favours requester 0.
- Opcodes:
  - 00 = A & B.
  - 01 = A | B.
  - 10 = A ^ B.
  - 11 = ~A (B ignored).
  - All results are WIDTH bits with no carry and no flags.
- State IDLE:
  - gnt is combinational and asserts only in IDLE.
  - If only reqN is high, gntN = 1.
  - If both are high, grant the requester the pointer favours.
  - At most one gnt is high at a time.
  - On the edge where gntN = 1: capture opN/aN/bN and N into internal registers, then go to EXEC.
  - No request: stay in IDLE.
- State EXEC (1 cycle):
  - The logic unit computes from the captured operands.
  - On the edge: res_data <= result, res_id <= captured N, res_valid <= 1, go to HOLD.
- State HOLD:
  - res_valid, res_data and res_id are held stable until res_ack = 1.
  - On the edge with res_ack: res_valid <= 0, op_count <= op_count + 1 (wraps from 2^CNTW-1 to 0), pointer <= favour the requester other than res_id, go to IDLE.
  - res_ack outside HOLD is ignored.
- Latency:
  - From the grant edge to res_valid high is 2 edges.
  - Minimum issue interval is 3 cycles (IDLE, EXEC, HOLD with immediate ack).
- Requester rules:
  - req and operands must be stable until gnt.
  - Deasserting req before gnt withdraws the request with no side effect.
  - A requester keeping req high after its gnt is treated as a new request.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- Reset mid-operation: the in-flight operation is abandoned, no res_valid is produced, op_count is not incremented and the pointer returns to favour requester 0.
- Operand changes after capture have no effect on the in-flight result.

Decomposition:
- Shared package:
  - Opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11.
  - State encoding IDLE/EXEC/HOLD.
- Sub-module `logic_unit`: combinational WIDTH-bit operation selected by the 2-bit opcode, built from per-bit gate arrays in the same style as the existing bitwise blocks. It is instantiated once.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Single op, req0 only:
  - Stimulus: op0=00, a0=16'hF0F0, b0=16'hFF00, then res_ack the cycle after res_valid.
  - Required: gnt0 is a 1-cycle pulse, res_valid 2 edges later, res_data=16'hF000, res_id=0, op_count=1.
- All opcodes via req1 with a1=16'h00FF, b1=16'h0F0F:
  - Required results: AND=16'h000F, OR=16'h0FFF, XOR=16'h0FF0, NOT=16'hFF00.
- Contention, req0 and req1 held high for 4 operations with immediate ack:
  - Required: grant order 0,1,0,1 and res_id sequence 0,1,0,1.
- Ack stall:
  - Stimulus: withhold res_ack for 5 cycles while req1 pending.
  - Required: res_valid/res_data stable, no gnt1 until the cycle after ack.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during EXEC.
  - Required: all outputs 0 immediately (asynchronous), no res_valid after release. With both requesting, the first grant is gnt0.
- Counter wrap and withdrawal:
  - Counter: preload via 2^CNTW-1 ops (or CNTW=4 build with 15 ops); one more acked op gives op_count=0.
  - Withdrawal: req0 raised then dropped before IDLE produces no gnt0 and no count change.

Source files
------------

// File: rtl/alu_logic_arbiter_pkg.sv
// Purpose: shared opcode and FSM-state definitions for the logic-unit arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents: OP_* opcode constants and the state_t encoding.
package alu_logic_arbiter_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/alu_logic_arbiter_logic_unit.sv
// Purpose: WIDTH-bit bitwise AND/OR/XOR/NOT selected by a 2-bit opcode.
// Latency: purely combinational.
// Backpressure: none, the output always follows the inputs.
//
// Ports: op (opcode), a/b (operands, b unused for NOT), y (result).
module logic_unit
  import alu_logic_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] and_y;
  logic [WIDTH-1:0] or_y;
  logic [WIDTH-1:0] xor_y;
  logic [WIDTH-1:0] not_y;

  // One gate of each kind per bit position; the opcode only picks a row.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign and_y[i] = a[i] & b[i];
    assign or_y[i]  = a[i] | b[i];
    assign xor_y[i] = a[i] ^ b[i];
    assign not_y[i] = ~a[i];
  end

  always_comb begin
    y = and_y;
    case (op)
      OP_AND:  y = and_y;
      OP_OR:   y = or_y;
      OP_XOR:  y = xor_y;
      OP_NOT:  y = not_y;
      default: y = and_y;
    endcase
  end

endmodule

// File: rtl/alu_logic_arbiter.sv
// Purpose: round-robin share of one bitwise logic unit between two requesters.
// Latency: grant edge to res_valid is 2 edges; minimum issue interval 3 cycles.
// Backpressure: result held in HOLD until res_ack; no grants are issued meanwhile.
//
// Ports: clk/rst_n; per requester reqN/opN/aN/bN in, gntN out (combinational,
// IDLE only); res_valid/res_data/res_id out with res_ack in; busy; op_count.
module alu_logic_arbiter
  import alu_logic_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  input  logic             res_ack,
  output logic             busy,
  output logic [CNTW-1:0]  op_count
);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;        // 0 favours requester 0
  logic [1:0]       cap_op_q, cap_op_d;
  logic [WIDTH-1:0] cap_a_q, cap_a_d;
  logic [WIDTH-1:0] cap_b_q, cap_b_d;
  logic             cap_id_q, cap_id_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_id_q, res_id_d;
  logic [CNTW-1:0]  op_count_q, op_count_d;
  logic [WIDTH-1:0] lu_y;

  // The logic unit only ever sees captured operands, so requester-side
  // operand changes after the grant cannot disturb the in-flight result.
  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .op (cap_op_q),
    .a  (cap_a_q),
    .b  (cap_b_q),
    .y  (lu_y)
  );

  // Grants are gated by rst_n so every output reads 0 while reset is held,
  // even with requests pending.
  assign gnt0 = rst_n && (state_q == IDLE) && req0 && (!req1 || !ptr_q);
  assign gnt1 = rst_n && (state_q == IDLE) && req1 && (!req0 ||  ptr_q);

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = op_count_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cap_op_d    = cap_op_q;
    cap_a_d     = cap_a_q;
    cap_b_d     = cap_b_q;
    cap_id_d    = cap_id_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    op_count_d  = op_count_q;

    case (state_q)
      IDLE: begin
        if (gnt0) begin
          cap_op_d = op0;
          cap_a_d  = a0;
          cap_b_d  = b0;
          cap_id_d = 1'b0;
          state_d  = EXEC;
        end else if (gnt1) begin
          cap_op_d = op1;
          cap_a_d  = a1;
          cap_b_d  = b1;
          cap_id_d = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = lu_y;
        res_id_d    = cap_id_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ack) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + CNTW'(1);
          ptr_d       = ~res_id_q;   // next contention goes to the other side
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cap_op_q    <= 2'b00;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      cap_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cap_op_q    <= cap_op_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      cap_id_q    <= cap_id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      op_count_q  <= op_count_d;
    end
  end

endmodule
